ahb_slave_mem: RTL
==================

Name: ahb_slave_mem

Overview:
- AHB-Lite responder (subordinate) backed by a word-wide register-file memory.
- Sits on the bus opposite ahb_ctrl and gives the DMA path a target memory window with programmable wait states and ERROR responses.
- Supports single and back-to-back pipelined NONSEQ/SEQ word transfers.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the window
DEPTH, 16, number of 32-bit words (power of 2, 2..256)
WAIT_STATES, 1, hreadyout-low cycles inserted per OKAY data phase (0..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
hsel  input  1  slave select
htrans  input  2  transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
hsize  input  3  transfer size (only 3'b010 is legal)
hwrite  input  1  1 = write, 0 = read
haddr  input  32  byte address
hwdata  input  32  write data (data phase)
hreadyin  input  1  bus-level ready (tie to hreadyout for a single slave)
hreadyout  output  1  slave ready
hresp  output  1  0 = OKAY, 1 = ERROR
hrdata  output  32  read data

Behaviour:
- Reset (rst=0, async): hreadyout=1, hresp=0, hrdata=0, state=IDLE, all memory words=0, latched address-phase info cleared.
- Accept: an address phase is accepted at a clk edge when hsel && htrans[1] && hreadyin. On acceptance, latch hwrite, the word index, and the error flag.
  - Word index = (haddr-BASE_ADDR)>>2.
  - Error flag = (haddr-BASE_ADDR) >= DEPTH*4 || haddr[1:0]!=0 || hsize!=3'b010.
  - Address below BASE_ADDR wraps to a large offset and is therefore an error.
- IDLE/BUSY, or hsel=0: no data phase. Slave stays or returns to IDLE with hreadyout=1, hresp=0 (zero-wait OKAY).
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accept with error go to ERR1. On accept without error, go to WAIT if WAIT_STATES>0 (wait counter loaded with WAIT_STATES-1), else DATA.
  - WAIT: hreadyout=0, hresp=0. Decrement the counter; go to DATA when the counter is 0. New address phases are not sampled, because hreadyin=0.
  - DATA: hreadyout=1, hresp=0 (final data-phase cycle).
    - Read: hrdata = mem[index], read combinationally from the latched index.
    - Write: mem[index] <= hwdata at the closing edge.
    - The same edge may accept a new address phase; next state follows the IDLE rules. With no accept, return to IDLE.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory write; hrdata=0. The closing edge may accept a new address phase, following the IDLE rules.
- hrdata = 0 in every cycle that is not a read DATA cycle.
- Latency: OKAY transfer data phase = WAIT_STATES+1 cycles; ERROR = 2 cycles.
- Write then read to the same address back-to-back: the read returns the new data. The write commits at the edge that ends its DATA cycle, before the read's DATA cycle.
- Writes commit only in DATA, never in WAIT, ERR1 or ERR2.
- Reset asserted mid-transfer aborts it: any uncommitted write is dropped and outputs return to reset values immediately.
- hsel deasserted during WAIT does not cancel the in-flight data phase; it completes normally.
- Wait counter width is 4 bits; WAIT_STATES=0 bypasses WAIT entirely.

Test Plan:
- Reset: rst=0 for 3 cycles -> hreadyout=1, hresp=0, hrdata=0. A read of 0x0000_0008 after reset returns 0.
- Single write/read, WAIT_STATES=1:
  - NONSEQ write 0x0000_0004 with hwdata=0xDEADBEEF -> hreadyout low exactly 1 cycle, then high with hresp=0.
  - NONSEQ read 0x4 -> hrdata=0xDEADBEEF in the hreadyout=1 cycle, 0 otherwise.
- Pipelined, WAIT_STATES=0: write 0x0=0x11, write 0x4=0x22, read 0x0, read 0x4 on consecutive cycles -> hreadyout stays 1 throughout; reads return 0x11 then 0x22. Immediate write-then-read of 0x8=0x33 returns 0x33.
- ERROR responses, each expected as 2-cycle ERROR (hreadyout 0 then 1, hresp=1 both cycles) with memory unchanged:
  - write to 0x0000_0040 (DEPTH=16)
  - write to 0x0000_0002
  - hsize=3'b001
- IDLE/BUSY: htrans=0 or 1 with hsel=1, hwrite=1 -> hreadyout=1, hresp=0, no memory update (verify by readback).
- Reset mid-operation, WAIT_STATES=3: assert rst during the 2nd WAIT cycle of a write 0xC=0x55 -> after release, hreadyout=1 and a read of 0xC returns 0.

Source files
------------

// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite bus bundle between a master and the memory responder
interface ahb_slave_mem_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, htrans, hsize, hwrite, haddr, hwdata, hreadyin,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, htrans, hsize, hwrite, haddr, hwdata, hreadyin,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite word memory responder with wait states and ERROR responses
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    ahb_slave_mem_if.slave   bus
);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t             r_state;
    logic               r_hreadyout;
    logic               r_hresp;
    logic               r_write;
    logic [IDX_W-1:0]   r_index;
    logic [3:0]         r_cnt;
    logic [31:0]        r_mem [DEPTH];

    logic [31:0]        w_offset;
    logic               w_accept;
    logic               w_err;
    logic [IDX_W-1:0]   w_index;
    state_t             w_acc_state;
    logic               w_acc_ready;
    logic               w_acc_resp;

    // Addresses below BASE_ADDR wrap to a huge offset and land in the error range.
    assign w_offset = bus.haddr - BASE_ADDR;
    assign w_accept = bus.hsel && (bus.htrans == 2'b10 || bus.htrans == 2'b11) && bus.hreadyin;
    assign w_err    = (w_offset >= SPAN) || (bus.haddr[1:0] != 2'b00) || (bus.hsize != 3'b010);
    assign w_index  = w_offset[IDX_W+1:2];

    always_comb begin
        w_acc_state = ST_IDLE;
        w_acc_ready = 1'b1;
        w_acc_resp  = 1'b0;
        if (w_accept) begin
            if (w_err) begin
                w_acc_state = ST_ERR1;
                w_acc_ready = 1'b0;
                w_acc_resp  = 1'b1;
            end else if (WAIT_STATES > 0) begin
                w_acc_state = ST_WAIT;
                w_acc_ready = 1'b0;
            end else begin
                w_acc_state = ST_DATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_write     <= 1'b0;
            r_index     <= '0;
            r_cnt       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_DATA;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all end with hreadyout high, so a new address phase may land here.
                    if (r_state == ST_DATA && r_write) begin
                        r_mem[r_index] <= bus.hwdata;
                    end
                    r_state     <= w_acc_state;
                    r_hreadyout <= w_acc_ready;
                    r_hresp     <= w_acc_resp;
                    if (w_accept) begin
                        r_write <= bus.hwrite;
                        r_index <= w_index;
                        r_cnt   <= 4'(WAIT_STATES - 1);
                    end
                end
            endcase
        end
    end

    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.hrdata    = (r_state == ST_DATA && !r_write) ? r_mem[r_index] : 32'h0;
endmodule
